// File: rtl/switch_allocator_pkg.sv
// rtl/switch_allocator_pkg.sv - shared constants and helpers for the switch allocator
package switch_allocator_pkg;

    localparam int NPORT   = 5;
    localparam int LABEL_W = 5;
    localparam int PTR_W   = 3;

    localparam int PORT_L = 0;
    localparam int PORT_W = 1;
    localparam int PORT_N = 2;
    localparam int PORT_E = 3;
    localparam int PORT_S = 4;

    // Round-robin successor: the port after the winner, wrapping S back to L.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
        return (w == PTR_W'(NPORT - 1)) ? '0 : w + PTR_W'(1);
    endfunction

endpackage

// File: rtl/switch_allocator_rr.sv
// rtl/switch_allocator_rr.sv - combinational 5-way round-robin arbiter
module rr_arbiter_5
    import switch_allocator_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [NPORT-1:0] gnt,
    output logic [PTR_W-1:0] winner
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan from ptr upward with wrap; first requester wins unless the output is blocked.
    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NPORT; k++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(NPORT)) begin
                sum = sum - (PTR_W + 1)'(NPORT);
            end
            idx = sum[PTR_W-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - 5-port crossbar scheduler with multicast forking
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int DATASIZE = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT*DATASIZE-1:0] data_in,
    input  logic [NPORT*LABEL_W-1:0]  label_in,
    input  logic [NPORT-1:0]          full_in,
    output logic [NPORT-1:0]          ready_out,
    output logic [NPORT*DATASIZE-1:0] data_out,
    output logic [NPORT-1:0]          valid_out
);

    logic [LABEL_W-1:0]  served   [NPORT];
    logic [LABEL_W-1:0]  pending  [NPORT];
    logic [LABEL_W-1:0]  gset     [NPORT];
    logic [NPORT-1:0]    req      [NPORT];
    logic [NPORT-1:0]    gnt      [NPORT];
    logic [PTR_W-1:0]    winner   [NPORT];
    logic [PTR_W-1:0]    rr_ptr   [NPORT];
    logic [DATASIZE-1:0] win_data [NPORT];
    logic [NPORT-1:0]    arb_en;

    // The local port never backpressures; every other output is gated by its full flag.
    assign arb_en = {~full_in[NPORT-1:1], 1'b1};

    // Outstanding destinations per input, transposed into per-output request vectors.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            pending[i] = label_in[i*LABEL_W +: LABEL_W] & ~served[i];
        end
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = pending[i][o];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_arb
            rr_arbiter_5 u_arb (
                .req    (req[g]),
                .ptr    (rr_ptr[g]),
                .en     (arb_en[g]),
                .gnt    (gnt[g]),
                .winner (winner[g])
            );
        end
    endgenerate

    // Collect grants per input, decide release, and select the winning flit per output.
    always_comb begin
        ready_out = '0;
        for (int i = 0; i < NPORT; i++) begin
            gset[i] = '0;
            for (int o = 0; o < NPORT; o++) begin
                gset[i][o] = gnt[o][i];
            end
            ready_out[i] = (label_in[i*LABEL_W +: LABEL_W] != '0) &&
                           ((pending[i] & ~gset[i]) == '0);
        end
        for (int o = 0; o < NPORT; o++) begin
            win_data[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (gnt[o][i]) begin
                    win_data[o] = data_in[i*DATASIZE +: DATASIZE];
                end
            end
        end
    end

    // Output registers and round-robin pointers advance only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= '0;
            data_out  <= '0;
            for (int o = 0; o < NPORT; o++) begin
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                valid_out[o] <= |gnt[o];
                if (|gnt[o]) begin
                    data_out[o*DATASIZE +: DATASIZE] <= win_data[o];
                    rr_ptr[o] <= next_ptr(winner[o]);
                end
            end
        end
    end

    // Served masks accumulate partial multicast grants and clear once the flit is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPORT; i++) begin
                served[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (ready_out[i]) begin
                    served[i] <= '0;
                end else begin
                    served[i] <= served[i] | gset[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - self-checking bench for switch_allocator
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int DW = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NPORT*DW-1:0] data_in;
    logic [NPORT*5-1:0]  label_in;
    logic [NPORT-1:0]    full_in;
    logic [NPORT-1:0]    ready_out;
    logic [NPORT*DW-1:0] data_out;
    logic [NPORT-1:0]    valid_out;

    switch_allocator #(.DATASIZE(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .label_in  (label_in),
        .full_in   (full_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus held by the bench
    logic [DW-1:0] dat [NPORT];
    logic [4:0]    lab [NPORT];
    logic [4:0]    full;
    logic [4:0]    obs_ready;

    // Reference model: which destinations each input has already had delivered,
    // and which input each output should favour next.
    logic [4:0]    m_served [NPORT];
    int            m_next   [NPORT];
    int            m_win    [NPORT];
    logic [4:0]    m_ready;
    logic [4:0]    m_valid;
    logic [DW-1:0] m_data   [NPORT];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NPORT; i++) begin
            data_in[i*DW +: DW] = dat[i];
            label_in[i*5 +: 5]  = lab[i];
        end
        full_in = full;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NPORT; i++) begin
            m_served[i] = '0;
            m_next[i]   = 0;
            m_data[i]   = '0;
        end
        m_valid = '0;
    endtask

    // Who gets each output this cycle, and which inputs end up fully delivered.
    task automatic model_eval();
        logic [4:0] got_now;
        for (int o = 0; o < NPORT; o++) begin
            m_win[o] = -1;
            if (o == 0 || !full[o]) begin
                for (int k = 0; k < NPORT; k++) begin
                    int i;
                    i = (m_next[o] + k) % NPORT;
                    if (m_win[o] < 0 && lab[i][o] && !m_served[i][o]) m_win[o] = i;
                end
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            got_now = '0;
            for (int o = 0; o < NPORT; o++) if (m_win[o] == i) got_now[o] = 1'b1;
            m_ready[i] = (lab[i] != 0) && ((lab[i] & ~m_served[i] & ~got_now) == 0);
        end
    endtask

    task automatic model_clock();
        for (int o = 0; o < NPORT; o++) begin
            if (m_win[o] >= 0) begin
                m_valid[o] = 1'b1;
                m_data[o]  = dat[m_win[o]];
                m_next[o]  = (m_win[o] + 1) % NPORT;
            end else begin
                m_valid[o] = 1'b0;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            if (m_ready[i]) m_served[i] = '0;
            else for (int o = 0; o < NPORT; o++) if (m_win[o] == i) m_served[i][o] = 1'b1;
        end
    endtask

    // One clock cycle: present inputs, check release, clock, check registered outputs.
    task automatic cyc();
        apply();
        #1;
        model_eval();
        obs_ready = ready_out;
        chk("ready", 32'(ready_out), 32'(m_ready));
        @(posedge clk);
        model_clock();
        #1;
        chk("valid", 32'(valid_out), 32'(m_valid));
        for (int o = 0; o < NPORT; o++) begin
            chk($sformatf("data%0d", o), 32'(data_out[o*DW +: DW]), 32'(m_data[o]));
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NPORT; i++) begin
            lab[i] = '0;
            dat[i] = '0;
        end
        full = '0;
    endtask

    initial begin
        int cnt [NPORT];
        int seq [3];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] a0;
        logic [DW-1:0] a3;

        // Reset with traffic present: no contention, so every labelled input is released.
        clear_inputs();
        for (int i = 0; i < NPORT; i++) begin
            lab[i] = 5'(1 << ((i + 1) % NPORT));
            dat[i] = DW'($urandom);
        end
        rst = 1'b1;
        model_reset();
        apply();
        #2;
        model_eval();
        chk("rst_ready", 32'(ready_out), 32'h1f);
        chk("rst_ready_model", 32'(ready_out), 32'(m_ready));
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(valid_out), 32'h0);
            chk("rst_data", (data_out == '0) ? 32'h1 : 32'h0, 32'h1);
        end
        clear_inputs();
        apply();
        rst = 1'b0;
        cyc();

        // First unicast flit L -> E
        lab[0] = 5'b01000;
        dat[0] = DW'(32'h1234);
        cyc();
        chk("first_ready", 32'(obs_ready[0]), 32'h1);
        chk("first_valid", 32'(valid_out[3]), 32'h1);
        chk("first_data", 32'(data_out[3*DW +: DW]), 32'h1234);
        lab[0] = '0;

        // Backpressure on E
        lab[2] = 5'b01000;
        dat[2] = DW'(32'h0bad5eed);
        full   = 5'b01000;
        repeat (4) begin
            cyc();
            chk("bp_ready", 32'(obs_ready[2]), 32'h0);
            chk("bp_valid", 32'(valid_out[3]), 32'h0);
        end
        full = '0;
        cyc();
        chk("bp_rel_ready", 32'(obs_ready[2]), 32'h1);
        chk("bp_rel_valid", 32'(valid_out[3]), 32'h1);
        chk("bp_rel_data", 32'(data_out[3*DW +: DW]), 32'h0bad5eed);
        lab[2] = '0;

        // Multicast fork with S full
        lab[0] = 5'b11010;
        dat[0] = DW'(32'h00c0ffee);
        full   = 5'b10000;
        cyc();
        chk("fork1_valid", 32'(valid_out), 32'b01010);
        chk("fork1_ready", 32'(obs_ready[0]), 32'h0);
        cyc();
        chk("fork2_valid", 32'(valid_out), 32'b00000);
        chk("fork2_ready", 32'(obs_ready[0]), 32'h0);
        full = '0;
        cyc();
        chk("fork3_valid", 32'(valid_out), 32'b10000);
        chk("fork3_data", 32'(data_out[4*DW +: DW]), 32'h00c0ffee);
        chk("fork3_ready", 32'(obs_ready[0]), 32'h1);
        lab[0] = '0;
        cyc();

        // Contention: W, N, S all to L, round-robin W, N, S, ...
        seq[0] = 1; seq[1] = 2; seq[2] = 4;
        for (int i = 0; i < NPORT; i++) cnt[i] = 0;
        foreach (seq[k]) begin
            lab[seq[k]] = 5'b00001;
            dat[seq[k]] = DW'(seq[k] * 256);
        end
        for (int c = 0; c < 9; c++) begin
            exp_d = dat[seq[c % 3]];
            cyc();
            chk("cont_valid", 32'(valid_out[0]), 32'h1);
            chk("cont_data", 32'(data_out[0 +: DW]), 32'(exp_d));
            foreach (seq[k]) begin
                if (obs_ready[seq[k]]) begin
                    cnt[seq[k]]++;
                    dat[seq[k]] = DW'(seq[k] * 256 + cnt[seq[k]]);
                end
            end
        end
        foreach (seq[k]) chk($sformatf("cont_cnt%0d", seq[k]), 32'(cnt[seq[k]]), 32'd3);
        clear_inputs();
        cyc();

        // Multicast contention: steer N's pointer to E by a U-turn N -> N first.
        lab[2] = 5'b00100;
        dat[2] = DW'(32'h777);
        cyc();
        lab[2] = '0;
        a0 = DW'(32'h0a0a0);
        a3 = DW'(32'h0e0e0);
        lab[0] = 5'b00110; dat[0] = a0;
        lab[3] = 5'b00100; dat[3] = a3;
        cyc();
        chk("mc1_valid", 32'(valid_out), 32'b00110);
        chk("mc1_dataN", 32'(data_out[2*DW +: DW]), 32'(a3));
        chk("mc1_dataW", 32'(data_out[1*DW +: DW]), 32'(a0));
        chk("mc1_ready", 32'(obs_ready), 32'b01000);
        lab[3] = '0;
        cyc();
        chk("mc2_valid", 32'(valid_out), 32'b00100);
        chk("mc2_dataN", 32'(data_out[2*DW +: DW]), 32'(a0));
        chk("mc2_ready", 32'(obs_ready[0]), 32'h1);
        lab[0] = '0;
        cyc();

        // Reset in the middle of a multicast
        lab[0] = 5'b11010;
        dat[0] = DW'(32'h2abcde);
        full   = 5'b10000;
        cyc();
        chk("rm_part_valid", 32'(valid_out), 32'b01010);
        chk("rm_part_ready", 32'(obs_ready[0]), 32'h0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rm_async", 32'(valid_out), 32'h0);
        @(posedge clk);
        #1;
        chk("rm_hold", 32'(valid_out), 32'h0);
        rst  = 1'b0;
        full = '0;
        cyc();
        chk("rm_resend_valid", 32'(valid_out), 32'b11010);
        chk("rm_resend_data", 32'(data_out[4*DW +: DW]), 32'h2abcde);
        chk("rm_resend_ready", 32'(obs_ready[0]), 32'h1);
        lab[0] = '0;
        full   = '0;
        cyc();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (lab[i] == 0 || m_ready[i]) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r < 3)      lab[i] = '0;
                    else if (r < 7) lab[i] = 5'(1 << $urandom_range(0, 4));
                    else            lab[i] = 5'($urandom_range(1, 31));
                    dat[i] = DW'($urandom);
                end
            end
            full = 5'($urandom & $urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
